// File: rtl/mcs4_rom_bus_seq.sv
// rtl/mcs4_rom_bus_seq.sv - MCS-4 ROM bus master: 8-phase timing, nibble address, cm/cl control
module mcs4_rom_bus_seq #(
  parameter logic [3:0] OPA_WRR = 4'h2,
  parameter logic [3:0] OPA_RDR = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [11:0] req_addr,
  input  logic [3:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        clr_req,
  output logic        sync,
  output logic        cl_rom,
  output logic        cm_rom,
  output logic [3:0]  dbus_out,
  input  logic [3:0]  dbus_in,
  output logic [2:0]  phase,
  output logic        busy
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0, K_SRC = 2'd1, K_WRR = 2'd2, K_RDR = 2'd3
  } kind_t;

  phase_t      r_phase;
  phase_t      w_phase_next;
  logic        r_active;
  logic        r_clr_cyc;
  logic        r_clr_pend;
  kind_t       r_kind;
  logic [11:0] r_addr;
  logic [3:0]  r_data;
  logic [3:0]  r_hi;
  logic [7:0]  r_rsp_data;
  logic        w_accept;

  // Requests are only taken at X3 so the op occupies exactly the next A1..X3 window;
  // a pending clear blocks acceptance so the following cycle can be a clear cycle.
  assign req_ready = (r_phase == PH_X3) && !r_clr_pend && !rst;
  assign w_accept  = req_valid && req_ready;

  assign sync     = (r_phase == PH_X3);
  assign cl_rom   = r_clr_cyc;
  assign busy     = r_active;
  assign phase    = r_phase;
  assign rsp_data = r_rsp_data;

  // Phase state register: reset parks at X3 so the first A1 aligns with the ROMs' count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_X3;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Next phase: free-running 0..7 wrap.
  always_comb begin
    w_phase_next = PH_A1;
    if (r_phase != PH_X3) begin
      w_phase_next = phase_t'(r_phase + 3'd1);
    end
  end

  // Instruction-cycle ownership: decide at each X3 whether the next cycle is an op, a clear, or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active   <= 1'b0;
      r_clr_cyc  <= 1'b0;
      r_clr_pend <= 1'b0;
    end else if (r_phase == PH_X3) begin
      r_active   <= w_accept;
      r_clr_cyc  <= r_clr_pend;
      // Entering a clear cycle consumes the pending flag; a clr_req seen now re-arms it.
      r_clr_pend <= clr_req;
    end else begin
      r_clr_pend <= r_clr_pend | clr_req;
    end
  end

  // Request latch: host inputs are don't-care once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind <= K_FETCH;
      r_addr <= 12'h000;
      r_data <= 4'h0;
    end else if (w_accept) begin
      r_kind <= kind_t'(req_kind);
      r_addr <= req_addr;
      r_data <= req_data;
    end
  end

  // Read-data capture: fetch byte arrives high nibble at M1, low at M2; RDR nibble at X2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi       <= 4'h0;
      r_rsp_data <= 8'h00;
    end else if (r_active) begin
      if (r_kind == K_FETCH && r_phase == PH_M1) begin
        r_hi <= dbus_in;
      end
      if (r_kind == K_FETCH && r_phase == PH_M2) begin
        r_rsp_data <= {r_hi, dbus_in};
      end
      if (r_kind == K_RDR && r_phase == PH_X2) begin
        r_rsp_data <= {4'h0, dbus_in};
      end
    end
  end

  // Bus drive and command/response strobes, decoded from registered phase and op.
  always_comb begin
    dbus_out  = 4'h0;
    cm_rom    = 1'b0;
    rsp_valid = 1'b0;
    if (r_active) begin
      case (r_phase)
        PH_A1: dbus_out = r_addr[3:0];
        PH_A2: dbus_out = r_addr[7:4];
        PH_A3: dbus_out = r_addr[11:8];
        PH_M2: begin
          if (r_kind == K_WRR) begin
            dbus_out = OPA_WRR;
            cm_rom   = 1'b1;
          end else if (r_kind == K_RDR) begin
            dbus_out = OPA_RDR;
            cm_rom   = 1'b1;
          end
        end
        PH_X1: rsp_valid = (r_kind == K_FETCH);
        PH_X2: begin
          if (r_kind == K_SRC) begin
            dbus_out = r_data;
            cm_rom   = 1'b1;
          end else if (r_kind == K_WRR) begin
            // Data only: cm_rom stays low so the ROMs keep their chip select.
            dbus_out = r_data;
          end
        end
        PH_X3: rsp_valid = (r_kind == K_RDR);
        default: ;
      endcase
    end
  end

endmodule
